// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: reset PC, bus widths, branch bus layout, NOP.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC        = 32'h1bff_fffc;
    localparam int          FS_TO_DS_BUS_WD = 64;
    localparam int          BR_BUS_WD       = 34;

    // andi $r0, $r0, 0
    localparam logic [31:0] INST_NOP        = 32'h0340_0000;

    typedef struct packed {
        logic        br_stall;
        logic        br_taken;
        logic [31:0] br_target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Pre-IF + IF stage: next-PC generation, instruction SRAM requests and the IF latch.
// Define IF_INST_BUF_EN to hold stalled instructions in a skid buffer instead of re-reading the SRAM.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic                       br_stall,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

    logic [31:0] fs_pc_reg;
    logic [31:0] fs_pc_next;
    logic        fs_valid_reg;
    logic        fs_valid_next;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        to_fs_valid;
    logic        fs_allowin;
    logic        fetch_fire;
    logic [31:0] fs_inst;
    fs_to_ds_t   fs_bus;

    assign seq_pc = next_seq_pc(fs_pc_reg);
    assign nextpc = br_taken ? br_target : seq_pc;

    // A redirect cancels the IF instruction, so it is always accepted and overrides br_stall.
    assign fs_allowin  = ~fs_valid_reg | ds_allowin | br_taken;
    assign to_fs_valid = ~reset & (~br_stall | br_taken);
    assign fetch_fire  = to_fs_valid & fs_allowin;

    always_comb begin
        fs_pc_next    = fs_pc_reg;
        fs_valid_next = fs_valid_reg;
        if (fetch_fire) begin
            fs_pc_next    = nextpc;
            fs_valid_next = 1'b1;
        end else if (fs_allowin) begin
            fs_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_pc_reg    <= RESET_PC;
            fs_valid_reg <= 1'b0;
        end else begin
            fs_pc_reg    <= fs_pc_next;
            fs_valid_reg <= fs_valid_next;
        end
    end

`ifdef IF_INST_BUF_EN
    logic [31:0] inst_buf_reg;
    logic [31:0] inst_buf_next;
    logic        buf_valid_reg;
    logic        buf_valid_next;
    logic        ds_stall;

    assign ds_stall = fs_valid_reg & ~ds_allowin & ~br_taken;

    // Capture rdata on the first stalled cycle; the SRAM is idle afterwards.
    always_comb begin
        inst_buf_next  = inst_buf_reg;
        buf_valid_next = buf_valid_reg;
        if (ds_allowin || br_taken) begin
            buf_valid_next = 1'b0;
        end else if (ds_stall && !buf_valid_reg) begin
            inst_buf_next  = inst_sram_rdata;
            buf_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_buf_reg  <= 32'b0;
            buf_valid_reg <= 1'b0;
        end else begin
            inst_buf_reg  <= inst_buf_next;
            buf_valid_reg <= buf_valid_next;
        end
    end

    assign fs_inst        = buf_valid_reg ? inst_buf_reg : inst_sram_rdata;
    assign inst_sram_en   = fetch_fire;
    assign inst_sram_addr = nextpc;
`else
    // Without a buffer, keep rdata stable by re-reading fs_pc while IF is held.
    assign fs_inst        = inst_sram_rdata;
    assign inst_sram_en   = ~reset & (fetch_fire | fs_valid_reg);
    assign inst_sram_addr = fetch_fire ? nextpc : fs_pc_reg;
`endif

    assign inst_sram_we    = 4'b0;
    assign inst_sram_wdata = 32'b0;

    assign fs_bus.inst     = fs_inst;
    assign fs_bus.pc       = fs_pc_reg;
    assign fs_to_ds_valid  = fs_valid_reg & ~br_taken;
    // An empty IF presents an all-zero bus, including right after reset.
    assign fs_to_ds_bus    = fs_valid_reg ? fs_bus : '0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, decode stall, redirects, branch stall, reset mid-stall.
// The SRAM model returns the requested address as data, one cycle after an enabled request.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'b0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;

    int check_cnt = 0;
    int pass_cnt  = 0;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_stall        (br_stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #20000;
        check_cnt++;
        $error("FAIL watchdog: observed timeout expected finish");
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ds_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0; br_target = 32'b0;
        next_cycle(); next_cycle();

        // Reset state
        sample();
        check("rst_en",    {63'b0, inst_sram_en},   64'd0);
        check("rst_valid", {63'b0, fs_to_ds_valid}, 64'd0);
        check("rst_bus",   fs_to_ds_bus,            64'd0);
        check("rst_we",    {60'b0, inst_sram_we},   64'd0);

        // Sequential fetch
        next_cycle(); reset = 1'b0;
        sample();
        check("seq0_en",    {63'b0, inst_sram_en},   64'd1);
        check("seq0_addr",  {32'b0, inst_sram_addr}, 64'h1c000000);
        check("seq0_valid", {63'b0, fs_to_ds_valid}, 64'd0);
        next_cycle(); sample();
        check("seq1_valid", {63'b0, fs_to_ds_valid}, 64'd1);
        check("seq1_bus",   fs_to_ds_bus,            64'h1c000000_1c000000);
        check("seq1_addr",  {32'b0, inst_sram_addr}, 64'h1c000004);
        next_cycle(); sample();
        check("seq2_bus",   fs_to_ds_bus,            64'h1c000004_1c000004);
        check("seq2_addr",  {32'b0, inst_sram_addr}, 64'h1c000008);

        // Decode stall for 3 cycles holding 0x1c000008
        next_cycle(); ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("stall_bus",   fs_to_ds_bus,            64'h1c000008_1c000008);
            check("stall_valid", {63'b0, fs_to_ds_valid}, 64'd1);
`ifdef IF_INST_BUF_EN
            check("stall_en",    {63'b0, inst_sram_en},   64'd0);
`endif
            if (i < 2) next_cycle();
        end
        next_cycle(); ds_allowin = 1'b1;
        sample();
        check("rel_bus",  fs_to_ds_bus,            64'h1c000008_1c000008);
        check("rel_addr", {32'b0, inst_sram_addr}, 64'h1c00000c);
        next_cycle(); sample();
        check("rel_next", fs_to_ds_bus,            64'h1c00000c_1c00000c);

        // Redirect while IF holds 0x1c000010
        next_cycle(); br_taken = 1'b1; br_target = 32'h1c000100;
        sample();
        check("br_pc_held", fs_to_ds_bus[31:0] == 32'h1c000010 ? 64'd1 : 64'd0, 64'd1);
        check("br_valid",   {63'b0, fs_to_ds_valid}, 64'd0);
        check("br_addr",    {32'b0, inst_sram_addr}, 64'h1c000100);
        next_cycle(); br_taken = 1'b0;
        sample();
        check("br_tgt_bus", fs_to_ds_bus,            64'h1c000100_1c000100);
        check("br_tgt_vld", {63'b0, fs_to_ds_valid}, 64'd1);

        // Redirect during a decode stall
        next_cycle(); ds_allowin = 1'b0;
        sample();
        check("brst_hold",  fs_to_ds_bus,            64'h1c000104_1c000104);
        next_cycle(); br_taken = 1'b1; br_target = 32'h1c000200;
        sample();
        check("brst_valid", {63'b0, fs_to_ds_valid}, 64'd0);
        check("brst_en",    {63'b0, inst_sram_en},   64'd1);
        check("brst_addr",  {32'b0, inst_sram_addr}, 64'h1c000200);
        next_cycle(); br_taken = 1'b0; ds_allowin = 1'b1;
        sample();
        check("brst_bus",   fs_to_ds_bus,            64'h1c000200_1c000200);

        // Branch stall for 2 cycles with decode ready
        next_cycle(); br_stall = 1'b1;
        sample();
        check("bs_valid0", {63'b0, fs_to_ds_valid}, 64'd1);
        check("bs_bus0",   fs_to_ds_bus,            64'h1c000204_1c000204);
`ifdef IF_INST_BUF_EN
        check("bs_en0",    {63'b0, inst_sram_en},   64'd0);
`endif
        next_cycle(); sample();
        check("bs_valid1", {63'b0, fs_to_ds_valid}, 64'd0);
`ifdef IF_INST_BUF_EN
        check("bs_en1",    {63'b0, inst_sram_en},   64'd0);
`endif
        next_cycle(); br_stall = 1'b0;
        sample();
        check("bs_en_res", {63'b0, inst_sram_en},   64'd1);
        check("bs_addr",   {32'b0, inst_sram_addr}, 64'h1c000208);
        next_cycle(); sample();
        check("bs_bus",    fs_to_ds_bus,            64'h1c000208_1c000208);

        // br_stall and br_taken together: redirect wins
        next_cycle(); br_stall = 1'b1; br_taken = 1'b1; br_target = 32'h1c000300;
        sample();
        check("both_en",   {63'b0, inst_sram_en},   64'd1);
        check("both_addr", {32'b0, inst_sram_addr}, 64'h1c000300);
        next_cycle(); br_stall = 1'b0; br_taken = 1'b0;
        sample();
        check("both_bus",  fs_to_ds_bus,            64'h1c000300_1c000300);

        // PC wrap at the top of the address space
        next_cycle(); br_taken = 1'b1; br_target = 32'hfffffffc;
        next_cycle(); br_taken = 1'b0;
        sample();
        check("wrap_bus",  fs_to_ds_bus,            64'hfffffffc_fffffffc);
        check("wrap_addr", {32'b0, inst_sram_addr}, 64'h0);

        // Reset asserted during a decode stall
        next_cycle(); ds_allowin = 1'b0;
        next_cycle(); reset = 1'b1;
        sample();
        check("mrst_en",    {63'b0, inst_sram_en},   64'd0);
        next_cycle(); ds_allowin = 1'b1;
        sample();
        check("mrst_valid", {63'b0, fs_to_ds_valid}, 64'd0);
        check("mrst_bus",   fs_to_ds_bus,            64'd0);
        next_cycle(); reset = 1'b0;
        sample();
        check("mrst_addr",  {32'b0, inst_sram_addr}, 64'h1c000000);
        next_cycle(); sample();
        check("mrst_first", fs_to_ds_bus,            64'h1c000000_1c000000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
